// File: rtl/count8_down.sv
// rtl/count8_down.sv - loadable down counter with terminal-count pulse and optional periodic reload
// Load has priority over counting; expiry either parks at zero or reloads the last loaded value.
module count8_down #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] Q,
    output logic             zero,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ZERO_V = '0;
    localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_busy;
    logic             r_tc;

    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_r_nxt;
    logic             w_busy_nxt;
    logic             w_tc_nxt;
    logic             w_step;
    logic             w_expire;

    // busy guarantees r_q >= 1, so a step either decrements or expires.
    assign w_step   = en && r_busy;
    assign w_expire = (r_q == ONE_V);

    always_comb begin
        w_q_nxt    = r_q;
        w_r_nxt    = r_r;
        w_busy_nxt = r_busy;
        w_tc_nxt   = 1'b0;
        if (load) begin
            w_q_nxt    = D;
            w_r_nxt    = D;
            w_busy_nxt = (D != ZERO_V);
        end else if (w_step) begin
            if (w_expire) begin
                w_tc_nxt = 1'b1;
                if (auto_reload) begin
                    w_q_nxt = r_r;
                end else begin
                    w_q_nxt    = ZERO_V;
                    w_busy_nxt = 1'b0;
                end
            end else begin
                w_q_nxt = r_q - ONE_V;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q    <= ZERO_V;
            r_r    <= ZERO_V;
            r_busy <= 1'b0;
            r_tc   <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_r    <= w_r_nxt;
            r_busy <= w_busy_nxt;
            r_tc   <= w_tc_nxt;
        end
    end

    assign Q    = r_q;
    assign zero = (r_q == ZERO_V);
    assign tc   = r_tc;
    assign busy = r_busy;

endmodule

// File: tb/tb_count8_down.sv
// tb/tb_count8_down.sv - directed and randomized checks of count8_down against a behavioural model
module tb_count8_down;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] D;
    logic       en;
    logic       auto_reload;
    logic [7:0] Q;
    logic       zero;
    logic       tc;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // model state: remaining count, period, running flag, pulse
    int m_left;
    int m_period;
    bit m_run;
    bit m_pulse;

    count8_down #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .load(load), .D(D), .en(en),
        .auto_reload(auto_reload), .Q(Q), .zero(zero), .tc(tc), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_left = 0; m_period = 0; m_run = 0; m_pulse = 0;
        end else if (load) begin
            m_left = int'(D); m_period = int'(D); m_run = (D != 0); m_pulse = 0;
        end else if (en && m_run) begin
            m_left = m_left - 1;
            m_pulse = (m_left == 0);
            if (m_left == 0) begin
                if (auto_reload) m_left = m_period;
                else m_run = 0;
            end
        end else begin
            m_pulse = 0;
        end
    endtask

    task automatic step(input bit rst, input bit ld, input int d, input bit e, input bit ar);
        reset = rst; load = ld; D = 8'(d); en = e; auto_reload = ar;
        @(posedge clk);
        model_edge();
        #1;
        chk("q", int'(Q), m_left);
        chk("zero", int'(zero), int'(m_left == 0));
        chk("tc", int'(tc), int'(m_pulse));
        chk("busy", int'(busy), int'(m_run));
    endtask

    initial begin
        int tc_count;
        bit per_en [7];
        int per_q [8];
        per_en = '{1, 1, 0, 1, 1, 1, 1};
        per_q  = '{3, 2, 1, 1, 3, 2, 1, 3};
        m_left = 0; m_period = 0; m_run = 0; m_pulse = 0;
        reset = 1; load = 0; D = 0; en = 0; auto_reload = 0;

        // reset then idle with en high
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_zero", int'(zero), 1);
        chk("rst_busy", int'(busy), 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
        chk("idle_q", int'(Q), 0);

        // one-shot from 5
        step(0, 1, 5, 1, 0);
        chk("os_load", int'(Q), 5);
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 0, 1, 0);
            chk("os_seq", int'(Q), 5 - i);
            chk("os_tc", int'(tc), int'(i == 5));
        end
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);
        chk("os_park", int'(Q), 0);

        // periodic with enable gaps
        step(0, 1, 3, 0, 1);
        chk("per_q0", int'(Q), per_q[0]);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0, per_en[i], 1);
            chk("per_seq", int'(Q), per_q[i+1]);
            chk("per_tc", int'(tc), int'(i == 3 || i == 6));
        end

        // load collision
        step(0, 1, 9, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        chk("col_six", int'(Q), 6);
        step(0, 1, 2, 1, 0);
        chk("col_load", int'(Q), 2);
        step(0, 0, 0, 1, 0);
        chk("col_one", int'(Q), 1);
        step(0, 0, 0, 1, 0);
        chk("col_zero", int'(Q), 0);
        chk("col_tc", int'(tc), 1);

        // load 0 with en high, both modes
        step(0, 1, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, i[0]);
            chk("d0_tc", int'(tc), 0);
        end

        // period 1: tc every cycle, Q held at 1
        step(0, 1, 1, 1, 1);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 1, 1);
            chk("p1_tc", int'(tc), 1);
            chk("p1_q", int'(Q), 1);
        end

        // full range: 255 enabled cycles to expiry
        step(0, 1, 255, 0, 0);
        tc_count = 0;
        for (int i = 0; i < 255; i++) begin
            step(0, 0, 0, 1, 0);
            if (tc) tc_count++;
        end
        chk("full_q", int'(Q), 0);
        chk("full_tc", tc_count, 1);

        // reset mid-count
        step(0, 1, 200, 0, 1);
        for (int i = 0; i < 50; i++) step(0, 0, 0, 1, 1);
        chk("mid_q", int'(Q), 150);
        step(1, 0, 0, 1, 1);
        chk("mid_rst_q", int'(Q), 0);
        chk("mid_rst_busy", int'(busy), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
        chk("mid_after", int'(Q), 0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit r_rst, r_ld, r_en, r_ar;
            int r_d;
            r_rst = ($urandom_range(0, 199) == 0);
            r_ld  = ($urandom_range(0, 9) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_ar  = ($urandom_range(0, 1) == 1);
            r_d   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
            step(r_rst, r_ld, r_d, r_en, r_ar);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
